// File: rtl/data_mem_port_if.sv
// data_mem_port_if
//   Bundles the pipeline-side load/store request and the memory-bus
//   handshake of the data memory port.
//   Pipeline side : mem_read, mem_write, addr, wdata  -> port
//                   stall, mem_data, mem_valid, mem_err <- port
//   Memory side   : bus_req, bus_we, bus_addr, bus_wdata <- port
//                   bus_rdata, bus_ack                  -> port
//   Modports: slave  = the port itself (data_mem_port)
//             master = the environment (pipeline + memory) driving it
interface data_mem_port_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              stall;
  logic [DATA_W-1:0] mem_data;
  logic              mem_valid;
  logic              mem_err;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack;

  modport slave (
    input  mem_read, mem_write, addr, wdata, bus_rdata, bus_ack,
    output stall, mem_data, mem_valid, mem_err,
           bus_req, bus_we, bus_addr, bus_wdata
  );

  modport master (
    output mem_read, mem_write, addr, wdata, bus_rdata, bus_ack,
    input  stall, mem_data, mem_valid, mem_err,
           bus_req, bus_we, bus_addr, bus_wdata
  );
endinterface

// File: rtl/data_mem_port.sv
// data_mem_port
//   Load/store port between the 8-bit MIPS MEM stage and a variable-latency
//   memory bus. Accepts one load or store, runs a req/ack transaction,
//   stalls the pipeline meanwhile and returns the load byte on mem_data.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous reset, active-high
//     bus  - data_mem_port_if.slave (pipeline request/response + memory bus)
//   Outputs other than stall are registered; stall is combinational.
module data_mem_port #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  data_mem_port_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Last REQ cycle index: entering REQ sets cnt to 0, so TIMEOUT REQ cycles
  // end when cnt reaches TIMEOUT-1.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_err_q, mem_err_d;
  logic              stall_s;

  // Next-state, datapath latching and stall decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    mem_data_d  = mem_data_q;
    mem_valid_d = 1'b0;
    mem_err_d   = 1'b0;
    stall_s     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.mem_read ^ bus.mem_write) begin
          bus_addr_d  = bus.addr;
          bus_wdata_d = bus.wdata;
          bus_we_d    = bus.mem_write;
          cnt_d       = 8'd0;
          bus_req_d   = 1'b1;
          stall_s     = 1'b1;
          state_d     = ST_REQ;
        end else if (bus.mem_read & bus.mem_write) begin
          // Illegal request: flag it, never touch the bus, do not stall.
          mem_err_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_REQ: begin
        stall_s = 1'b1;
        cnt_d   = cnt_q + 8'd1;
        // Ack is checked first so an ack on the timeout cycle completes normally.
        if (bus.bus_ack) begin
          bus_req_d   = 1'b0;
          mem_valid_d = 1'b1;
          state_d     = ST_DONE;
          if (!bus_we_q) begin
            mem_data_d = bus.bus_rdata;
          end else begin
            mem_data_d = mem_data_q;
          end
        end else if (cnt_q == CNT_LAST) begin
          bus_req_d   = 1'b0;
          mem_valid_d = 1'b1;
          mem_err_d   = 1'b1;
          state_d     = ST_DONE;
          if (!bus_we_q) begin
            mem_data_d = {DATA_W{1'b0}};
          end else begin
            mem_data_d = mem_data_q;
          end
        end else begin
          state_d = ST_REQ;
        end
      end

      ST_DONE: begin
        // Any request seen here is picked up again in IDLE next cycle.
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        bus_req_d = 1'b0;
      end
    endcase

    // Reset releases the pipeline immediately, not one edge later.
    if (rst) begin
      stall_s = 1'b0;
    end else begin
      stall_s = stall_s;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= {ADDR_W{1'b0}};
      bus_wdata_q <= {DATA_W{1'b0}};
      mem_data_q  <= {DATA_W{1'b0}};
      mem_valid_q <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      mem_data_q  <= mem_data_d;
      mem_valid_q <= mem_valid_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign bus.stall     = stall_s;
  assign bus.mem_data  = mem_data_q;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_err   = mem_err_q;
  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_data_mem_port.sv
// tb_data_mem_port
//   Directed bench for data_mem_port: reset state, load with immediate ack,
//   store with delayed ack, timeout, ack on the timeout cycle, illegal
//   read+write request with a stray ack, and reset in the middle of REQ.
//   Inputs change 1 ns after the rising edge; outputs are checked 2 ns after
//   the rising edge, once combinational stall has settled.
module tb_data_mem_port;

  logic clk;
  logic rst;
  int   test_cnt;
  int   fail_cnt;
  int   req_cycles;

  data_mem_port_if #(.ADDR_W(8), .DATA_W(8)) mp ();

  data_mem_port #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mp.slave)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge (input drive point)
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs follow freshly driven inputs
  task automatic settle();
    #1;
  endtask

  initial begin
    test_cnt         = 0;
    fail_cnt         = 0;
    rst              = 1'b1;
    mp.mem_read      = 1'b0;
    mp.mem_write     = 1'b0;
    mp.addr          = 8'h00;
    mp.wdata         = 8'h00;
    mp.bus_rdata     = 8'h00;
    mp.bus_ack       = 1'b0;

    // Reset state
    tick(); tick();
    settle();
    check_eq("rst_bus_req",   32'(mp.bus_req),   32'd0);
    check_eq("rst_mem_data",  32'(mp.mem_data),  32'h00);
    check_eq("rst_mem_valid", 32'(mp.mem_valid), 32'd0);
    check_eq("rst_mem_err",   32'(mp.mem_err),   32'd0);
    check_eq("rst_stall",     32'(mp.stall),     32'd0);
    rst = 1'b0;
    tick();

    // 1: load 0x10, ack on first REQ cycle with 0xA5
    mp.mem_read = 1'b1; mp.addr = 8'h10;
    settle();
    check_eq("t1_stall_c0",   32'(mp.stall),   32'd1);
    check_eq("t1_req_c0",     32'(mp.bus_req), 32'd0);
    tick();
    mp.bus_ack = 1'b1; mp.bus_rdata = 8'hA5;
    settle();
    check_eq("t1_req_c1",     32'(mp.bus_req),  32'd1);
    check_eq("t1_stall_c1",   32'(mp.stall),    32'd1);
    check_eq("t1_addr_c1",    32'(mp.bus_addr), 32'h10);
    check_eq("t1_we_c1",      32'(mp.bus_we),   32'd0);
    tick();
    mp.bus_ack = 1'b0; mp.mem_read = 1'b0;
    settle();
    check_eq("t1_valid_c2",   32'(mp.mem_valid), 32'd1);
    check_eq("t1_data_c2",    32'(mp.mem_data),  32'hA5);
    check_eq("t1_stall_c2",   32'(mp.stall),     32'd0);
    check_eq("t1_req_c2",     32'(mp.bus_req),   32'd0);
    check_eq("t1_err_c2",     32'(mp.mem_err),   32'd0);
    tick();
    settle();
    check_eq("t1_valid_c3",   32'(mp.mem_valid), 32'd0);
    check_eq("t1_data_hold",  32'(mp.mem_data),  32'hA5);

    // 2: store 0x3C to 0x20, ack on the 4th REQ cycle
    mp.mem_write = 1'b1; mp.addr = 8'h20; mp.wdata = 8'h3C;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        mp.bus_ack = 1'b1; mp.bus_rdata = 8'hEE;
      end else begin
        mp.bus_ack = 1'b0;
      end
      settle();
      check_eq("t2_req",   32'(mp.bus_req),   32'd1);
      check_eq("t2_we",    32'(mp.bus_we),    32'd1);
      check_eq("t2_wdata", 32'(mp.bus_wdata), 32'h3C);
      check_eq("t2_addr",  32'(mp.bus_addr),  32'h20);
      check_eq("t2_valid", 32'(mp.mem_valid), 32'd0);
      tick();
    end
    mp.bus_ack = 1'b0; mp.mem_write = 1'b0;
    settle();
    check_eq("t2_valid_done", 32'(mp.mem_valid), 32'd1);
    check_eq("t2_err_done",   32'(mp.mem_err),   32'd0);
    check_eq("t2_data_kept",  32'(mp.mem_data),  32'hA5);
    tick();
    settle();
    check_eq("t2_valid_after", 32'(mp.mem_valid), 32'd0);

    // 3: load with no ack -> timeout after exactly 15 REQ cycles
    mp.mem_read = 1'b1; mp.addr = 8'h30;
    tick();
    req_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      settle();
      if (mp.bus_req !== 1'b1) break;
      req_cycles++;
      tick();
    end
    mp.mem_read = 1'b0;
    settle();
    check_eq("t3_req_cycles", 32'(req_cycles),   32'd15);
    check_eq("t3_err",        32'(mp.mem_err),   32'd1);
    check_eq("t3_valid",      32'(mp.mem_valid), 32'd1);
    check_eq("t3_data",       32'(mp.mem_data),  32'h00);
    tick();
    settle();
    check_eq("t3_err_after",  32'(mp.mem_err),   32'd0);
    check_eq("t3_stall_idle", 32'(mp.stall),     32'd0);
    check_eq("t3_req_idle",   32'(mp.bus_req),   32'd0);

    // 4: ack on the 15th REQ cycle wins over timeout
    mp.mem_read = 1'b1; mp.addr = 8'h40;
    tick();
    for (int i = 0; i < 15; i++) begin
      if (i == 14) begin
        mp.bus_ack = 1'b1; mp.bus_rdata = 8'h77;
      end else begin
        mp.bus_ack = 1'b0;
      end
      settle();
      check_eq("t4_req", 32'(mp.bus_req), 32'd1);
      tick();
    end
    mp.bus_ack = 1'b0; mp.mem_read = 1'b0;
    settle();
    check_eq("t4_valid", 32'(mp.mem_valid), 32'd1);
    check_eq("t4_err",   32'(mp.mem_err),   32'd0);
    check_eq("t4_data",  32'(mp.mem_data),  32'h77);
    tick();

    // 5: illegal read+write, then a stray ack in IDLE
    mp.mem_read = 1'b1; mp.mem_write = 1'b1; mp.addr = 8'h55;
    settle();
    check_eq("t5_stall", 32'(mp.stall), 32'd0);
    tick();
    mp.mem_read = 1'b0; mp.mem_write = 1'b0;
    mp.bus_ack = 1'b1; mp.bus_rdata = 8'hEE;
    settle();
    check_eq("t5_err",        32'(mp.mem_err),   32'd1);
    check_eq("t5_req",        32'(mp.bus_req),   32'd0);
    check_eq("t5_valid",      32'(mp.mem_valid), 32'd0);
    tick();
    mp.bus_ack = 1'b0;
    settle();
    check_eq("t5_err_after",  32'(mp.mem_err),   32'd0);
    check_eq("t5_req_after",  32'(mp.bus_req),   32'd0);
    check_eq("t5_valid_ack",  32'(mp.mem_valid), 32'd0);
    check_eq("t5_data_kept",  32'(mp.mem_data),  32'h77);

    // 6: reset during REQ, ack after reset ignored, then a clean load
    mp.mem_read = 1'b1; mp.addr = 8'h50;
    tick(); tick(); tick();
    settle();
    check_eq("t6_req_before", 32'(mp.bus_req), 32'd1);
    rst = 1'b1; mp.mem_read = 1'b0;
    settle();
    check_eq("t6_req_rst",   32'(mp.bus_req),   32'd0);
    check_eq("t6_stall_rst", 32'(mp.stall),     32'd0);
    check_eq("t6_data_rst",  32'(mp.mem_data),  32'h00);
    check_eq("t6_addr_rst",  32'(mp.bus_addr),  32'h00);
    mp.bus_ack = 1'b1; mp.bus_rdata = 8'h99;
    tick();
    rst = 1'b0;
    tick();
    settle();
    check_eq("t6_ack_ign_req",   32'(mp.bus_req),   32'd0);
    check_eq("t6_ack_ign_valid", 32'(mp.mem_valid), 32'd0);
    check_eq("t6_ack_ign_data",  32'(mp.mem_data),  32'h00);
    mp.bus_ack = 1'b0;
    mp.mem_read = 1'b1; mp.addr = 8'h60;
    tick();
    mp.bus_ack = 1'b1; mp.bus_rdata = 8'h5A;
    settle();
    check_eq("t6_new_req",  32'(mp.bus_req),  32'd1);
    check_eq("t6_new_addr", 32'(mp.bus_addr), 32'h60);
    tick();
    mp.bus_ack = 1'b0; mp.mem_read = 1'b0;
    settle();
    check_eq("t6_new_valid", 32'(mp.mem_valid), 32'd1);
    check_eq("t6_new_data",  32'(mp.mem_data),  32'h5A);
    tick();

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
